// File: rtl/mem_pkg.sv
// Shared constants, loader state encoding and byte-lane merge helper for the
// unified instruction/data memory responder.
package mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DONE
  } ld_state_e;

  // Lanes with be set take the new byte; all other lanes keep the old byte.
  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0]   old_w,
                                                 input logic [DATA_W-1:0]   new_w,
                                                 input logic [DATA_W/8-1:0] be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < DATA_W / 8; i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered,
// write-first read port. Contents are not reset; only the read register is.
module sp_ram_be #(
  parameter int ADDR_W    = mem_pkg::ADDR_W,
  parameter int DATA_W    = mem_pkg::DATA_W,
  parameter int DEPTH     = 1 << ADDR_W,
  parameter     INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);
  import mem_pkg::*;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] merged;

  assign merged = be_merge(mem[addr], wdata, be);

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= merged;
  end

  // Read register only advances when re is high, so it holds across loader writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= we ? merged : mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/unified_mem_responder.sv
// Memory-side responder for the shared core port plus a streaming program loader
// that owns the RAM port (and stalls the core) while a load is in progress.
module unified_mem_responder #(
  parameter int ADDR_W    = mem_pkg::ADDR_W,
  parameter int DATA_W    = mem_pkg::DATA_W,
  parameter int DEPTH     = 1 << ADDR_W,
  parameter     INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_rw_mode,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_byte_en,
  output logic [DATA_W-1:0]   mem_rdata,
  input  logic                ld_start,
  input  logic [ADDR_W-1:0]   ld_base,
  input  logic [ADDR_W:0]     ld_len,
  input  logic                ld_valid,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                ld_ready,
  output logic                ld_done,
  output logic                core_hold
);
  import mem_pkg::*;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;

  logic                idle;
  logic                ld_fire;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W/8-1:0] ram_be;

  assign idle      = (state_q == LD_IDLE);
  assign ld_ready  = (state_q == LD_LOAD);
  assign ld_done   = (state_q == LD_DONE);
  assign core_hold = !idle;
  assign ld_fire   = ld_ready && ld_valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      LD_IDLE: begin
        if (ld_start) begin
          ptr_d   = ld_base;
          cnt_d   = '0;
          len_d   = ld_len;
          state_d = (ld_len != '0) ? LD_LOAD : LD_DONE;
        end
      end
      LD_LOAD: begin
        if (ld_valid) begin
          // DEPTH is a power of two, so the pointer wraps to 0 on its own.
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) state_d = LD_DONE;
        end
      end
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign ram_we    = ld_fire || (idle && mem_rw_mode);
  assign ram_addr  = ld_fire ? ptr_q   : mem_addr;
  assign ram_wdata = ld_fire ? ld_data : mem_wdata;
  assign ram_be    = ld_fire ? '1      : mem_byte_en;

  sp_ram_be #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .re   (idle),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .be   (ram_be),
    .rdata(mem_rdata)
  );

  a_ld_len_legal : assert property (@(posedge clk) disable iff (!rst_n)
    (idle && ld_start) |-> (ld_len <= (ADDR_W+1)'(DEPTH)))
    else $error("ld_len exceeds DEPTH");

endmodule

// File: tb/tb_unified_mem_responder.sv
// Scoreboard bench for unified_mem_responder: core reads/writes, loader runs,
// zero-length loads, ignored restarts and reset mid-load.
module tb_unified_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  mem_addr;
  logic        mem_rw_mode;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        ld_start;
  logic [9:0]  ld_base;
  logic [10:0] ld_len;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        core_hold;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model [1024];
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  unified_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_addr   (mem_addr),
    .mem_rw_mode(mem_rw_mode),
    .mem_wdata  (mem_wdata),
    .mem_byte_en(mem_byte_en),
    .mem_rdata  (mem_rdata),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_len     (ld_len),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .core_hold  (core_hold)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic core_op(input string tag, input logic rw, input logic [9:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] m;
    @(negedge clk);
    mem_rw_mode = rw; mem_addr = a; mem_wdata = wd; mem_byte_en = be;
    if (rw) begin
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      model[a] = (model[a] & ~m) | (wd & m);
    end
    sb.push_back(model[a]);
    @(posedge clk); #1;
    chk(tag, mem_rdata, sb.pop_front());
    mem_rw_mode = 1'b0;
  endtask

  task automatic run_load(input logic [9:0] base, input logic [10:0] len,
                          input logic [31:0] d0, input bit toggle, input bit poke_start);
    int acc = 0;
    int dones = 0;
    int cyc = 0;
    bit seen = 0;
    bit fire;
    logic [31:0] hold_rd;
    logic [9:0] a;
    @(negedge clk);
    ld_start = 1'b1; ld_base = base; ld_len = len;
    mem_rw_mode = 1'b0; mem_addr = 10'h005;
    hold_rd = model[10'h005];
    @(posedge clk); #1;
    chk("ld_start_cycle_read", mem_rdata, hold_rd);
    ld_start = 1'b0;
    @(negedge clk);
    // Hostile arbiter traffic and a restart attempt that must both be ignored.
    ld_start = poke_start; ld_base = 10'h200; ld_len = 11'd1;
    mem_rw_mode = 1'b1; mem_addr = 10'h005; mem_wdata = 32'hBAD0BAD0; mem_byte_en = 4'hF;
    ld_valid = 1'b0;
    while (!seen && cyc < 64) begin
      ld_valid = toggle ? ~ld_valid : 1'b1;
      ld_data  = d0 + 32'(acc);
      #1;
      fire = ld_valid && ld_ready;
      chk("core_hold_during_load", {31'd0, core_hold}, 32'd1);
      if (ld_done) begin
        dones++;
        seen = 1;
      end
      @(posedge clk); #1;
      if (fire) begin
        a = base + 10'(acc);
        model[a] = d0 + 32'(acc);
        acc++;
      end
      ld_start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!seen) chk("ld_timeout", 32'd0, 32'd1);
    ld_valid = 1'b0;
    mem_rw_mode = 1'b0;
    #1;
    chk("ld_done_once", {31'd0, ld_done}, 32'd0);
    chk("core_hold_after", {31'd0, core_hold}, 32'd0);
    chk("ld_ready_after", {31'd0, ld_ready}, 32'd0);
    chk("ld_words_accepted", 32'(acc), 32'(len));
    chk("ld_done_pulses", 32'(dones), 32'd1);
    chk("rdata_held_in_load", mem_rdata, hold_rd);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_addr = '0; mem_rw_mode = 1'b0; mem_wdata = '0; mem_byte_en = '0;
    ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    #2;
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_ld_done", {31'd0, ld_done}, 32'd0);
    chk("rst_core_hold", {31'd0, core_hold}, 32'd0);
    #20;
    @(negedge clk); rst_n = 1'b1;

    core_op("wr_full", 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    core_op("rd_full", 1'b0, 10'h010, 32'h0, 4'h0);
    core_op("wr_lane0", 1'b1, 10'h010, 32'h000000AA, 4'h1);
    core_op("wr_be0", 1'b1, 10'h010, 32'hFFFFFFFF, 4'h0);
    core_op("rd_merged", 1'b0, 10'h010, 32'h0, 4'h0);
    chk("merged_const", model[10'h010], 32'hDEADBEAA);
    core_op("wr_first", 1'b1, 10'h020, 32'h12345678, 4'hF);
    core_op("wr_hi_lanes", 1'b1, 10'h020, 32'hA5A5_0000, 4'hC);

    core_op("wr_0x005", 1'b1, 10'h005, 32'h55AA55AA, 4'hF);
    run_load(10'h3FE, 11'd4, 32'd1, 1'b1, 1'b0);
    core_op("ld_3FE", 1'b0, 10'h3FE, 32'h0, 4'h0);
    core_op("ld_3FF", 1'b0, 10'h3FF, 32'h0, 4'h0);
    core_op("ld_000", 1'b0, 10'h000, 32'h0, 4'h0);
    core_op("ld_001", 1'b0, 10'h001, 32'h0, 4'h0);
    chk("ld_wrap_const", model[10'h001], 32'd4);
    core_op("arb_ignored", 1'b0, 10'h005, 32'h0, 4'h0);

    // Zero-length load goes straight to DONE.
    @(negedge clk);
    ld_start = 1'b1; ld_base = 10'h3FE; ld_len = 11'd0;
    @(posedge clk); #1;
    ld_start = 1'b0;
    chk("len0_done", {31'd0, ld_done}, 32'd1);
    chk("len0_hold", {31'd0, core_hold}, 32'd1);
    chk("len0_ready", {31'd0, ld_ready}, 32'd0);
    @(posedge clk); #1;
    chk("len0_done_fall", {31'd0, ld_done}, 32'd0);
    chk("len0_hold_fall", {31'd0, core_hold}, 32'd0);
    core_op("len0_nochange", 1'b0, 10'h3FE, 32'h0, 4'h0);

    core_op("wr_0x200", 1'b1, 10'h200, 32'hCAFEF00D, 4'hF);
    run_load(10'h100, 11'd2, 32'h0000_0100, 1'b0, 1'b1);
    core_op("ld_100", 1'b0, 10'h100, 32'h0, 4'h0);
    core_op("ld_101", 1'b0, 10'h101, 32'h0, 4'h0);
    core_op("restart_ignored", 1'b0, 10'h200, 32'h0, 4'h0);

    // Reset after two of five words have been accepted.
    @(negedge clk);
    ld_start = 1'b1; ld_base = 10'h050; ld_len = 11'd5;
    ld_valid = 1'b1; ld_data = 32'h0000_00A0;
    @(posedge clk); #1;
    ld_start = 1'b0;
    @(posedge clk); #1;
    model[10'h050] = 32'h0000_00A0;
    ld_data = 32'h0000_00A1;
    @(posedge clk); #1;
    model[10'h051] = 32'h0000_00A1;
    ld_data = 32'h0000_00A2;
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_rdata", mem_rdata, 32'd0);
    chk("abort_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("abort_ld_done", {31'd0, ld_done}, 32'd0);
    chk("abort_core_hold", {31'd0, core_hold}, 32'd0);
    ld_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    core_op("abort_w0", 1'b0, 10'h050, 32'h0, 4'h0);
    core_op("abort_w1", 1'b0, 10'h051, 32'h0, 4'h0);
    chk("abort_idle_hold", {31'd0, core_hold}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
